// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for a shared 3:1 datapath mux: registered one-hot grant, mux select,
// multi-cycle hold with optional timeout.
module mux3_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // Last allowed value of the hold counter; only meaningful when MAX_HOLD != 0.
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // First set bit of r scanning start, start+1, start+2 (mod 3); r must be non-zero.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] start);
    logic [1:0] i1, i2;
    i1 = inc3(start);
    i2 = inc3(i1);
    if (r[start]) return start;
    if (r[i1])    return i1;
    return i2;
  endfunction

  logic [1:0] holder_next;
  logic [1:0] idle_win;
  logic [1:0] cand_win;
  logic [2:0] cand;
  logic       hold_hit;
  logic       release_hit;

  assign holder_next = inc3(sel_q);
  assign idle_win    = rr_pick(req, ptr_q);
  assign cand        = req & ~onehot(sel_q);
  assign cand_win    = rr_pick(cand, holder_next);
  assign hold_hit    = (MAX_HOLD != 0) && (cnt_q == HoldLast);
  assign release_hit = done[sel_q] || !req[sel_q] || hold_hit;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          grant_d = onehot(idle_win);
          sel_d   = idle_win;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (release_hit) begin
          ptr_d     = holder_next;
          // Flag a timeout only when the counter was the sole reason for release.
          timeout_d = hold_hit && !done[sel_q] && req[sel_q];
          if (|cand) begin
            grant_d = onehot(cand_win);
            sel_d   = cand_win;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
            grant_d = 3'b000;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      grant_q   <= 3'b000;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
